// File: rtl/hilo_unit_pkg.sv
// HILO operation codes and default latencies shared by the controller and hilo_unit.
// The controller's HILOOp generation must use these same codes.
package hilo_unit_pkg;

    localparam logic [4:0] HILO_NONE  = 5'd0;
    localparam logic [4:0] HILO_MULT  = 5'd1;
    localparam logic [4:0] HILO_MULTU = 5'd2;
    localparam logic [4:0] HILO_DIV   = 5'd3;
    localparam logic [4:0] HILO_DIVU  = 5'd4;
    localparam logic [4:0] HILO_MFHI  = 5'd5;
    localparam logic [4:0] HILO_MFLO  = 5'd6;
    localparam logic [4:0] HILO_MTHI  = 5'd7;
    localparam logic [4:0] HILO_MTLO  = 5'd8;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/hilo_unit.sv
// E-stage multiply/divide unit: owns HI/LO and models multi-cycle latency with a busy counter.
// Results are computed at accept time and held pending until the counter expires.
module hilo_unit
    import hilo_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  HILOOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        req,
    output logic        start,
    output logic        busy,
    output logic [31:0] HILO_out
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    logic [31:0]     r_hi, r_lo, r_p_hi, r_p_lo;
    logic            r_p_upd;
    logic            r_busy;
    logic [CntW-1:0] r_cnt;

    logic            w_is_mul, w_is_div, w_accept;
    logic [63:0]     w_prod_s, w_prod_u;
    logic [31:0]     w_div_b, w_quo_s, w_rem_s, w_quo_u, w_rem_u;
    logic [31:0]     w_res_hi, w_res_lo;

    assign w_is_mul = (HILOOp == HILO_MULT) || (HILOOp == HILO_MULTU);
    assign w_is_div = (HILOOp == HILO_DIV) || (HILOOp == HILO_DIVU);
    assign w_accept = (w_is_mul || w_is_div) && !req && !r_busy;

    // Both 64-bit products computed on explicitly extended operands.
    assign w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign w_prod_u = {32'd0, A} * {32'd0, B};

    // Substitute divisor 1 on divide-by-zero; the result is discarded via r_p_upd.
    assign w_div_b = (B == 32'd0) ? 32'd1 : B;
    assign w_quo_s = $signed(A) / $signed(w_div_b);
    assign w_rem_s = $signed(A) % $signed(w_div_b);
    assign w_quo_u = A / w_div_b;
    assign w_rem_u = A % w_div_b;

    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        case (HILOOp)
            HILO_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
            HILO_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
            HILO_DIV: begin
                w_res_hi = w_rem_s;
                w_res_lo = w_quo_s;
            end
            HILO_DIVU: begin
                w_res_hi = w_rem_u;
                w_res_lo = w_quo_u;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_p_hi  <= 32'd0;
            r_p_lo  <= 32'd0;
            r_p_upd <= 1'b0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_p_hi  <= w_res_hi;
            r_p_lo  <= w_res_lo;
            r_p_upd <= !(w_is_div && (B == 32'd0));
            r_busy  <= 1'b1;
            r_cnt   <= w_is_mul ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
        end else if (r_busy) begin
            // In-flight ops are committed: req does not cancel them, new ops are ignored.
            if (r_cnt == CntW'(1)) begin
                if (r_p_upd) begin
                    r_hi <= r_p_hi;
                    r_lo <= r_p_lo;
                end
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt - CntW'(1);
            end
        end else if (!req) begin
            if (HILOOp == HILO_MTHI) r_hi <= A;
            if (HILOOp == HILO_MTLO) r_lo <= A;
        end
    end

    always_comb begin
        HILO_out = 32'd0;
        if (HILOOp == HILO_MFHI) HILO_out = r_hi;
        if (HILOOp == HILO_MFLO) HILO_out = r_lo;
    end

    assign start = w_accept;
    assign busy  = r_busy;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed self-checking bench for hilo_unit with default latencies (mult 5, div 10).
module tb_hilo_unit;
    import hilo_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  HILOOp = HILO_NONE;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        req = 1'b0;
    logic        start, busy;
    logic [31:0] HILO_out;

    int checks = 0;
    int failures = 0;

    hilo_unit dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .HILOOp   (HILOOp),
        .A        (A),
        .B        (B),
        .req      (req),
        .start    (start),
        .busy     (busy),
        .HILO_out (HILO_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        HILOOp  = HILO_MFHI;
        #3;
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL reset_busy got=%b exp=0", busy);
            failures++;
        end
        checks++;
        if (HILO_out !== 32'd0) begin
            $display("FAIL reset_hi got=%h exp=00000000", HILO_out);
            failures++;
        end
        step();
        reset_n = 1'b1;
        HILOOp  = HILO_NONE;
        #1;
        checks++;
        if (start !== 1'b0) begin
            $display("FAIL reset_start got=%b exp=0", start);
            failures++;
        end
        step();
    endtask

    task automatic test_mult();
        HILOOp = HILO_MULT; A = 32'hFFFF_FFFF; B = 32'd2;
        #1;
        checks++;
        if (start !== 1'b1) begin
            $display("FAIL mult_start got=%b exp=1", start);
            failures++;
        end
        step();
        HILOOp = HILO_NONE;
        #1;
        checks++;
        if (start !== 1'b0) begin
            $display("FAIL mult_start_once got=%b exp=0", start);
            failures++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (busy !== 1'b1) begin
                $display("FAIL mult_busy[%0d] got=%b exp=1", i, busy);
                failures++;
            end
            step();
        end
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL mult_busy_end got=%b exp=0", busy);
            failures++;
        end
        HILOOp = HILO_MFHI;
        #1;
        checks++;
        if (HILO_out !== 32'hFFFF_FFFF) begin
            $display("FAIL mult_hi got=%h exp=ffffffff", HILO_out);
            failures++;
        end
        HILOOp = HILO_MFLO;
        #1;
        checks++;
        if (HILO_out !== 32'hFFFF_FFFE) begin
            $display("FAIL mult_lo got=%h exp=fffffffe", HILO_out);
            failures++;
        end
        step();
    endtask

    task automatic test_multu();
        HILOOp = HILO_MULTU; A = 32'hFFFF_FFFF; B = 32'd2;
        step();
        HILOOp = HILO_NONE;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (busy !== 1'b1) begin
                $display("FAIL multu_busy[%0d] got=%b exp=1", i, busy);
                failures++;
            end
            step();
        end
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL multu_busy_end got=%b exp=0", busy);
            failures++;
        end
        HILOOp = HILO_MFHI;
        #1;
        checks++;
        if (HILO_out !== 32'h0000_0001) begin
            $display("FAIL multu_hi got=%h exp=00000001", HILO_out);
            failures++;
        end
        HILOOp = HILO_MFLO;
        #1;
        checks++;
        if (HILO_out !== 32'hFFFF_FFFE) begin
            $display("FAIL multu_lo got=%h exp=fffffffe", HILO_out);
            failures++;
        end
        step();
    endtask

    task automatic test_div();
        HILOOp = HILO_DIV; A = 32'hFFFF_FFF9; B = 32'd2;
        #1;
        checks++;
        if (start !== 1'b1) begin
            $display("FAIL div_start got=%b exp=1", start);
            failures++;
        end
        step();
        HILOOp = HILO_NONE;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (busy !== 1'b1) begin
                $display("FAIL div_busy[%0d] got=%b exp=1", i, busy);
                failures++;
            end
            step();
        end
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL div_busy_end got=%b exp=0", busy);
            failures++;
        end
        HILOOp = HILO_MFLO;
        #1;
        checks++;
        if (HILO_out !== 32'hFFFF_FFFD) begin
            $display("FAIL div_lo got=%h exp=fffffffd", HILO_out);
            failures++;
        end
        HILOOp = HILO_MFHI;
        #1;
        checks++;
        if (HILO_out !== 32'hFFFF_FFFF) begin
            $display("FAIL div_hi got=%h exp=ffffffff", HILO_out);
            failures++;
        end
        step();
    endtask

    task automatic test_divu_zero();
        HILOOp = HILO_MTHI; A = 32'h11;
        step();
        HILOOp = HILO_MTLO; A = 32'h22;
        step();
        HILOOp = HILO_DIVU; A = 32'd7; B = 32'd0;
        step();
        HILOOp = HILO_NONE;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (busy !== 1'b1) begin
                $display("FAIL divu0_busy[%0d] got=%b exp=1", i, busy);
                failures++;
            end
            // An MTLO arriving mid-flight must be ignored.
            if (i == 2) begin
                HILOOp = HILO_MTLO; A = 32'hDEAD;
                #1;
                checks++;
                if (start !== 1'b0) begin
                    $display("FAIL divu0_busy_start got=%b exp=0", start);
                    failures++;
                end
            end else begin
                HILOOp = HILO_NONE;
            end
            step();
        end
        HILOOp = HILO_NONE;
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL divu0_busy_end got=%b exp=0", busy);
            failures++;
        end
        HILOOp = HILO_MFHI;
        #1;
        checks++;
        if (HILO_out !== 32'h11) begin
            $display("FAIL divu0_hi got=%h exp=00000011", HILO_out);
            failures++;
        end
        HILOOp = HILO_MFLO;
        #1;
        checks++;
        if (HILO_out !== 32'h22) begin
            $display("FAIL divu0_lo got=%h exp=00000022", HILO_out);
            failures++;
        end
        step();
    endtask

    task automatic test_mt();
        HILOOp = HILO_MTHI; A = 32'h0000_1234;
        #1;
        checks++;
        if (start !== 1'b0) begin
            $display("FAIL mthi_start got=%b exp=0", start);
            failures++;
        end
        step();
        HILOOp = HILO_MFHI;
        #1;
        checks++;
        if (HILO_out !== 32'h0000_1234) begin
            $display("FAIL mthi_read got=%h exp=00001234", HILO_out);
            failures++;
        end
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL mthi_busy got=%b exp=0", busy);
            failures++;
        end
        HILOOp = HILO_MTLO; A = 32'h5555_AAAA; req = 1'b1;
        step();
        HILOOp = HILO_MFLO;
        #1;
        checks++;
        if (HILO_out !== 32'h22) begin
            $display("FAIL mtlo_req_lo got=%h exp=00000022", HILO_out);
            failures++;
        end
        req = 1'b0;
        step();
    endtask

    task automatic test_req();
        HILOOp = HILO_MULT; A = 32'd9; B = 32'd9; req = 1'b1;
        #1;
        checks++;
        if (start !== 1'b0) begin
            $display("FAIL req_start got=%b exp=0", start);
            failures++;
        end
        step();
        HILOOp = HILO_MFHI;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL req_busy got=%b exp=0", busy);
            failures++;
        end
        // req must not gate the read path.
        checks++;
        if (HILO_out !== 32'h0000_1234) begin
            $display("FAIL req_hi got=%h exp=00001234", HILO_out);
            failures++;
        end
        for (int i = 0; i < 6; i++) step();
        HILOOp = HILO_MFLO; req = 1'b0;
        #1;
        checks++;
        if (HILO_out !== 32'h22) begin
            $display("FAIL req_lo got=%h exp=00000022", HILO_out);
            failures++;
        end
        step();
    endtask

    task automatic test_req_inflight();
        HILOOp = HILO_MULT; A = 32'd3; B = 32'd5;
        step();
        HILOOp = HILO_NONE; req = 1'b1;
        step();
        req = 1'b0;
        for (int i = 1; i < 5; i++) begin
            checks++;
            if (busy !== 1'b1) begin
                $display("FAIL inflight_busy[%0d] got=%b exp=1", i, busy);
                failures++;
            end
            step();
        end
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL inflight_busy_end got=%b exp=0", busy);
            failures++;
        end
        HILOOp = HILO_MFLO;
        #1;
        checks++;
        if (HILO_out !== 32'd15) begin
            $display("FAIL inflight_lo got=%h exp=0000000f", HILO_out);
            failures++;
        end
        HILOOp = HILO_MFHI;
        #1;
        checks++;
        if (HILO_out !== 32'd0) begin
            $display("FAIL inflight_hi got=%h exp=00000000", HILO_out);
            failures++;
        end
        step();
    endtask

    task automatic test_async_reset();
        HILOOp = HILO_MTHI; A = 32'h0000_ABCD;
        step();
        HILOOp = HILO_DIV; A = 32'd100; B = 32'd7;
        step();
        HILOOp = HILO_NONE;
        for (int i = 0; i < 3; i++) step();
        // Now in busy cycle 4; drop reset between edges.
        HILOOp = HILO_MFHI;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL arst_busy got=%b exp=0", busy);
            failures++;
        end
        checks++;
        if (HILO_out !== 32'd0) begin
            $display("FAIL arst_hi got=%h exp=00000000", HILO_out);
            failures++;
        end
        HILOOp = HILO_MFLO;
        #1;
        checks++;
        if (HILO_out !== 32'd0) begin
            $display("FAIL arst_lo got=%h exp=00000000", HILO_out);
            failures++;
        end
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) step();
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL arst_late_busy got=%b exp=0", busy);
            failures++;
        end
        checks++;
        if (HILO_out !== 32'd0) begin
            $display("FAIL arst_late_lo got=%h exp=00000000", HILO_out);
            failures++;
        end
        HILOOp = HILO_NONE;
        #1;
        checks++;
        if (HILO_out !== 32'd0) begin
            $display("FAIL none_out got=%h exp=00000000", HILO_out);
            failures++;
        end
        step();
    endtask

    initial begin
        #1;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_divu_zero();
        test_mt();
        test_req();
        test_req_inflight();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
